// File: rtl/pll_lock_supervisor_if.sv
// PLL supervisor signal bundle: PLL handshake inputs plus supervisor status outputs.
// master = supervisor side, slave = PLL/system side.
interface pll_lock_supervisor_if #(
    parameter int unsigned MAX_RETRIES = 4
);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

    logic          pll_locked;
    logic          relock_req;
    logic          pll_rst;
    logic          sys_reset;
    logic [2:0]    sup_state;
    logic [RW-1:0] retry_cnt;
    logic          fault;
    logic [7:0]    loss_count;

    modport master (
        input  pll_locked, relock_req,
        output pll_rst, sys_reset, sup_state, retry_cnt, fault, loss_count
    );

    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, sys_reset, sup_state, retry_cnt, fault, loss_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on the reference clock: sequences PLL reset, lock qualification and system reset.
// Optional macro PLL_SUP_LOSS_COUNT_EN builds the saturating lock-loss counter; otherwise loss_count reads 0.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    pll_lock_supervisor_if.master  sup_if
);
    localparam int unsigned CNT_MAX =
        (RST_CYCLES > LOCK_TIMEOUT) ?
            ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES) :
            ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d, retry_inc;
    logic          sync1_q, sync2_q;
    logic          pll_rst_q, sys_reset_q, fault_q;
    logic          lock_s, fail;

    assign lock_s    = sync2_q;
    assign retry_inc = retry_q + 1'b1;

    // A failed attempt (timeout or lock drop during qualification) shares one retry/fault path.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        fail    = 1'b0;
        if (sup_if.relock_req) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        fail = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        fail = 1'b1;
                    end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = PLL_RST;
                        cnt_d   = '0;
                    end
                end
                FAULT: ;
                default: begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end
            endcase
            if (fail) begin
                retry_d = retry_inc;
                cnt_d   = '0;
                state_d = (retry_inc == RW'(MAX_RETRIES)) ? FAULT : PLL_RST;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            fault_q     <= 1'b0;
        end else begin
            sync1_q     <= sup_if.pll_locked;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == PLL_RST) || (state_d == FAULT);
            sys_reset_q <= (state_q != RUN);
            fault_q     <= (state_d == FAULT);
        end
    end

`ifdef PLL_SUP_LOSS_COUNT_EN
    logic [7:0] loss_q;
    logic       loss_inc;

    // A relock request in the same cycle as the drop supersedes it, so it is not counted.
    always_comb begin
        loss_inc = (state_q == RUN) && !lock_s && !sup_if.relock_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_q <= '0;
        end else if (loss_inc && (loss_q != '1)) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign sup_if.loss_count = loss_q;
`else
    assign sup_if.loss_count = '0;
`endif

    assign sup_if.pll_rst   = pll_rst_q;
    assign sup_if.sys_reset = sys_reset_q;
    assign sup_if.sup_state = state_q;
    assign sup_if.retry_cnt = retry_q;
    assign sup_if.fault     = fault_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pll_lock_supervisor;
    localparam int unsigned RST_C = 4;
    localparam int unsigned TO_C  = 32;
    localparam int unsigned ST_C  = 8;
    localparam int unsigned MR_C  = 2;
`ifdef PLL_SUP_LOSS_COUNT_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    pll_lock_supervisor_if #(.MAX_RETRIES(MR_C)) sup_if ();

    pll_lock_supervisor #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TO_C),
        .STABLE_CYCLES(ST_C),
        .MAX_RETRIES  (MR_C)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sup_if(sup_if)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic locked;
        logic relock;
        int   n;
        int   st;
        int   prst;
        int   sysr;
        int   flt;
        int   retry;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input int st, input int prst,
                              input int sysr, input int flt, input int retry);
        chk({tag, " sup_state"}, int'(sup_if.sup_state), st);
        chk({tag, " pll_rst"},   int'(sup_if.pll_rst),   prst);
        chk({tag, " sys_reset"}, int'(sup_if.sys_reset), sysr);
        chk({tag, " fault"},     int'(sup_if.fault),     flt);
        chk({tag, " retry_cnt"}, int'(sup_if.retry_cnt), retry);
    endtask

    task automatic wait_state(input int st, input int limit, input string tag);
        int k = 0;
        while (int'(sup_if.sup_state) != st && k < limit) begin
            step(1);
            k++;
        end
        chk({tag, " reached state"}, int'(sup_if.sup_state), st);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hi, first, n;
        sup_if.pll_locked = 1'b0;
        sup_if.relock_req = 1'b0;

        // Lock never arrives: two timeouts, fault, relock; then a clean lock to RUN.
        vecs[0]  = '{1'b0, 1'b0, 3,  0, 1, 1, 0, 0};
        vecs[1]  = '{1'b0, 1'b0, 1,  1, 0, 1, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 31, 1, 0, 1, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 1,  0, 1, 1, 0, 1};
        vecs[4]  = '{1'b0, 1'b0, 4,  1, 0, 1, 0, 1};
        vecs[5]  = '{1'b0, 1'b0, 32, 4, 1, 1, 1, 2};
        vecs[6]  = '{1'b0, 1'b0, 5,  4, 1, 1, 1, 2};
        vecs[7]  = '{1'b0, 1'b1, 1,  0, 1, 1, 0, 0};
        vecs[8]  = '{1'b1, 1'b0, 4,  1, 0, 1, 0, 0};
        vecs[9]  = '{1'b1, 1'b0, 1,  2, 0, 1, 0, 0};
        vecs[10] = '{1'b1, 1'b0, 7,  2, 0, 1, 0, 0};
        vecs[11] = '{1'b1, 1'b0, 1,  3, 0, 1, 0, 0};
        vecs[12] = '{1'b1, 1'b0, 1,  3, 0, 0, 0, 0};

        // Asynchronous reset takes effect before any clock edge.
        #2 rst = 1'b1;
        #1;
        check_outs("reset", 0, 1, 1, 0, 0);
        chk("reset loss_count", int'(sup_if.loss_count), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            sup_if.pll_locked = vecs[i].locked;
            sup_if.relock_req = vecs[i].relock;
            step(vecs[i].n);
            check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].prst,
                       vecs[i].sysr, vecs[i].flt, vecs[i].retry);
        end
        chk("table loss_count", int'(sup_if.loss_count), 0);

        // Power-up sequence: pll_rst width, then lock-to-release latency.
        sup_if.pll_locked = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (sup_if.pll_rst) hi++;
            step(1);
        end
        chk("seq1 pll_rst width", hi, 4);
        step(2);
        sup_if.pll_locked = 1'b1;
        step(1);
        n = 0;
        while (sup_if.sys_reset && n < 100) begin
            step(1);
            n++;
        end
        chk("seq1 sys_reset release cycles", n, 11);
        chk("seq1 sup_state", int'(sup_if.sup_state), 3);

        // One-cycle lock drop in RUN.
        sup_if.pll_locked = 1'b0;
        hi = 0;
        first = -1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (i == 0) sup_if.pll_locked = 1'b1;
            if (sup_if.pll_rst) hi++;
            if (sup_if.sys_reset && first < 0) first = i;
        end
        chk("seq3 sys_reset latency", first, 3);
        chk("seq3 pll_rst width", hi, 4);
        chk("seq3 loss_count", int'(sup_if.loss_count), LOSS_EN);
        wait_state(3, 60, "seq3 relock");
        step(1);
        chk("seq3 sys_reset after relock", int'(sup_if.sys_reset), 0);

        // Lock glitch seen during qualification at STABLE count 5.
        sup_if.relock_req = 1'b1;
        step(1);
        sup_if.relock_req = 1'b0;
        chk("seq4 relock state", int'(sup_if.sup_state), 0);
        wait_state(2, 20, "seq4 stable");
        step(3);
        sup_if.pll_locked = 1'b0;
        step(1);
        sup_if.pll_locked = 1'b1;
        step(2);
        check_outs("seq4 glitch", 0, 1, 1, 0, 1);
        wait_state(3, 60, "seq4 rerun");
        chk("seq4 retry cleared", int'(sup_if.retry_cnt), 0);

        // Relock request coinciding with synchronised lock loss in RUN.
        sup_if.pll_locked = 1'b0;
        step(2);
        sup_if.relock_req = 1'b1;
        step(1);
        sup_if.relock_req = 1'b0;
        chk("seq5 state", int'(sup_if.sup_state), 0);
        chk("seq5 loss_count", int'(sup_if.loss_count), LOSS_EN);
        chk("seq5 retry", int'(sup_if.retry_cnt), 0);

        // Asynchronous reset asserted between edges during WAIT_LOCK.
        wait_state(1, 20, "seq6 wait_lock");
        step(3);
        #5 rst = 1'b1;
        #1;
        check_outs("seq6 async reset", 0, 1, 1, 0, 0);
        chk("seq6 loss_count", int'(sup_if.loss_count), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("seq6 post-reset state", int'(sup_if.sup_state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
